fetch_stage: RTL and testbench

- Instruction-fetch front end of the 5-stage pipeline, directly upstream of the datapath's ID stage.
- Owns the program counter, the IF/ID pipeline register and the hardware return-address stack.
- Resolves PC redirects (relative branch, absolute jump, call, return) requested by the controller in ID. Inserts a single bubble on every redirect and honours stall requests from hazard detection.
- Instruction memory is external and combinational: this block drives the fetch address and receives the instruction in the same cycle.

---
 rtl/fetch_stage.sv | 118 +++++++++++
 tb/tb_fetch_stage.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: program counter, IF/ID register and return-address stack.
// Redirects flush one wrong-path slot; stall freezes every piece of state.
module fetch_stage #(
  parameter int PC_W        = 12,
  parameter int INST_W      = 19,
  parameter int STACK_DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         stall,
  input  logic [1:0]                   pc_mux,
  input  logic                         push,
  output logic [PC_W-1:0]              fetch_pc,
  input  logic [INST_W-1:0]            mem_instruction,
  output logic [INST_W-1:0]            IF_ID_instruction,
  output logic [PC_W-1:0]              IF_ID_pc,
  output logic                         IF_ID_valid,
  output logic [$clog2(STACK_DEPTH):0] stack_depth,
  output logic                         stack_err
);

  localparam int IDX_W   = $clog2(STACK_DEPTH);
  localparam int DEPTH_W = IDX_W + 1;

  logic [PC_W-1:0]    pc_p0;
  logic [INST_W-1:0]  instr_p1;
  logic [PC_W-1:0]    pc_p1;
  logic               vld_p1;
  logic [DEPTH_W-1:0] depth_q;
  logic               err_q;
  logic [PC_W-1:0]    stack_mem [STACK_DEPTH];

  logic [1:0]         sel;
  logic               do_push;
  logic [PC_W-1:0]    base;
  logic [PC_W-1:0]    top;
  logic [PC_W-1:0]    target;
  logic [IDX_W-1:0]   top_idx;
  logic [IDX_W-1:0]   stk_widx;
  logic               stk_we;
  logic               stk_empty;
  logic               stk_full;

  function automatic logic [PC_W-1:0] rel_target(input logic [PC_W-1:0] b,
                                                 input logic [7:0]      off);
    logic signed [PC_W-1:0] ext;
    ext = {{(PC_W-8){off[7]}}, off};
    return b + ext;
  endfunction

  // Redirect decode: controls from ID only count when the IF/ID slot holds a real instruction
  always_comb begin
    sel       = vld_p1 ? pc_mux : 2'b00;
    do_push   = vld_p1 & push;
    base      = pc_p1 + PC_W'(1);
    stk_empty = (depth_q == '0);
    stk_full  = (depth_q == DEPTH_W'(STACK_DEPTH));
    top_idx   = depth_q[IDX_W-1:0] - IDX_W'(1);
    top       = stack_mem[top_idx];
    case (sel)
      2'b01:   target = rel_target(base, instr_p1[7:0]);
      2'b10:   target = instr_p1[PC_W-1:0];
      2'b11:   target = stk_empty ? '0 : top;
      default: target = pc_p0 + PC_W'(1);
    endcase
    stk_we   = 1'b0;
    stk_widx = depth_q[IDX_W-1:0];
    if (!reset && !stall && do_push) begin
      if (sel == 2'b10 && !stk_full) begin
        stk_we = 1'b1;
      end else if (sel == 2'b11 && !stk_empty) begin
        stk_we   = 1'b1;
        stk_widx = top_idx;
      end
    end
  end

  // Stage p0 -> p1: PC update and IF/ID capture
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_p0    <= '0;
      instr_p1 <= '0;
      pc_p1    <= '0;
      vld_p1   <= 1'b0;
      depth_q  <= '0;
      err_q    <= 1'b0;
    end else if (!stall) begin
      pc_p0 <= target;
      pc_p1 <= pc_p0;
      if (sel == 2'b00) begin
        instr_p1 <= mem_instruction;
        vld_p1   <= 1'b1;
      end else begin
        instr_p1 <= '0;
        vld_p1   <= 1'b0;
      end
      if (sel == 2'b10 && do_push) begin
        if (stk_full) err_q   <= 1'b1;
        else          depth_q <= depth_q + DEPTH_W'(1);
      end else if (sel == 2'b11) begin
        if (stk_empty)     err_q   <= 1'b1;
        else if (!do_push) depth_q <= depth_q - DEPTH_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (stk_we) stack_mem[stk_widx] <= base;
  end

  assign fetch_pc          = pc_p0;
  assign IF_ID_instruction = instr_p1;
  assign IF_ID_pc          = pc_p1;
  assign IF_ID_valid       = vld_p1;
  assign stack_depth       = depth_q;
  assign stack_err         = err_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed redirect/stack scenarios plus randomized traffic,
// all checked against a queue-based behavioural model.
module tb_fetch_stage;

  localparam int PC_W   = 12;
  localparam int INST_W = 19;
  localparam int SD     = 8;
  localparam int DW     = 4;

  logic              clk = 1'b0;
  logic              reset, stall, push;
  logic [1:0]        pc_mux;
  logic [PC_W-1:0]   fetch_pc, IF_ID_pc;
  logic [INST_W-1:0] mem_instruction, IF_ID_instruction;
  logic              IF_ID_valid, stack_err;
  logic [DW-1:0]     stack_depth;

  logic [INST_W-1:0] mem [4096];

  int total = 0;
  int bad   = 0;

  int m_pc, m_ii, m_ip, m_v, m_err;
  int stk[$];

  fetch_stage #(.PC_W(PC_W), .INST_W(INST_W), .STACK_DEPTH(SD)) dut (
    .clk               (clk),
    .reset             (reset),
    .stall             (stall),
    .pc_mux            (pc_mux),
    .push              (push),
    .fetch_pc          (fetch_pc),
    .mem_instruction   (mem_instruction),
    .IF_ID_instruction (IF_ID_instruction),
    .IF_ID_pc          (IF_ID_pc),
    .IF_ID_valid       (IF_ID_valid),
    .stack_depth       (stack_depth),
    .stack_err         (stack_err)
  );

  always #5 clk = ~clk;

  always_comb mem_instruction = mem[fetch_pc];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Next-state of the fetch front end from the current inputs, using plain integer arithmetic.
  task automatic model_eval(output int n_pc, output int n_ii, output int n_ip, output int n_v);
    int mux, base, off, t;
    bit ps;
    if (reset) begin
      n_pc = 0; n_ii = 0; n_ip = 0; n_v = 0;
      m_err = 0;
      stk.delete();
    end else if (stall) begin
      n_pc = m_pc; n_ii = m_ii; n_ip = m_ip; n_v = m_v;
    end else begin
      mux  = (m_v != 0) ? int'(pc_mux) : 0;
      ps   = (m_v != 0) && push;
      base = (m_ip + 1) % 4096;
      n_ip = m_pc;
      t    = 0;
      if (mux == 0) begin
        n_pc = (m_pc + 1) % 4096;
        n_ii = int'(mem[m_pc]);
        n_v  = 1;
      end else begin
        n_ii = 0;
        n_v  = 0;
        if (mux == 1) begin
          off = m_ii % 256;
          if (off >= 128) off -= 256;
          t = (base + off + 4096) % 4096;
        end else if (mux == 2) begin
          t = m_ii % 4096;
          if (ps) begin
            if (stk.size() == SD) m_err = 1;
            else stk.push_back(base);
          end
        end else begin
          if (stk.size() == 0) begin
            t = 0;
            m_err = 1;
          end else begin
            t = stk[stk.size()-1];
            if (ps) stk[stk.size()-1] = base;
            else void'(stk.pop_back());
          end
        end
        n_pc = t;
      end
    end
  endtask

  task automatic step();
    int n_pc, n_ii, n_ip, n_v;
    model_eval(n_pc, n_ii, n_ip, n_v);
    @(posedge clk);
    #1;
    m_pc = n_pc; m_ii = n_ii; m_ip = n_ip; m_v = n_v;
    check("fetch_pc", fetch_pc, m_pc);
    check("if_id_instr", IF_ID_instruction, m_ii);
    check("if_id_pc", IF_ID_pc, m_ip);
    check("if_id_valid", IF_ID_valid, m_v);
    check("stack_depth", stack_depth, stk.size());
    check("stack_err", stack_err, m_err);
  endtask

  task automatic do_reset();
    reset = 1'b1; stall = 1'b0; push = 1'b0; pc_mux = 2'b00;
    step();
    reset = 1'b0;
  endtask

  task automatic run_to(input int target);
    int n = 0;
    pc_mux = 2'b00; push = 1'b0; stall = 1'b0;
    while (!(IF_ID_valid === 1'b1 && int'(IF_ID_pc) == target) && n < 5000) begin
      step();
      n++;
    end
    if (n >= 5000) check("run_to_timeout", IF_ID_pc, target);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; push = 1'b0; pc_mux = 2'b00;
    m_pc = 0; m_ii = 0; m_ip = 0; m_v = 0; m_err = 0;
    for (int k = 0; k < 4096; k++) mem[k] = INST_W'(k + 'h100);
    mem[5]     = INST_W'('h040);
    mem['h010] = INST_W'('h0FC);
    mem['hFFF] = INST_W'('h001);
    mem['h020] = INST_W'('h100);
    mem['h030] = INST_W'('h050);
    for (int i = 0; i < 9; i++) mem['h200 + i] = INST_W'('h201 + i);

    // Reset and free run
    step();
    step();
    check("rst_fetch_pc", fetch_pc, 0);
    check("rst_valid", IF_ID_valid, 0);
    check("rst_depth", stack_depth, 0);
    check("rst_err", stack_err, 0);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      check("seq_pc", IF_ID_pc, k);
      check("seq_instr", IF_ID_instruction, k + 'h100);
      check("seq_valid", IF_ID_valid, 1);
    end

    // Absolute jump from pc 5
    run_to(5);
    pc_mux = 2'b10;
    step();
    check("jmp_fetch_pc", fetch_pc, 'h040);
    check("jmp_bubble", IF_ID_valid, 0);
    pc_mux = 2'b00;
    step();
    check("jmp_arrive_pc", IF_ID_pc, 'h040);
    check("jmp_arrive_valid", IF_ID_valid, 1);

    // Relative branches, including wrap
    do_reset();
    run_to('h010);
    pc_mux = 2'b01;
    step();
    check("rel_back", fetch_pc, 'h00D);
    run_to('hFFF);
    pc_mux = 2'b01;
    step();
    check("rel_wrap", fetch_pc, 'h001);
    pc_mux = 2'b00;

    // Call and return
    do_reset();
    run_to('h020);
    push = 1'b1; pc_mux = 2'b10;
    step();
    push = 1'b0; pc_mux = 2'b00;
    check("call_target", fetch_pc, 'h100);
    check("call_depth", stack_depth, 1);
    run_to('h105);
    pc_mux = 2'b11;
    step();
    pc_mux = 2'b00;
    check("ret_target", fetch_pc, 'h021);
    check("ret_depth", stack_depth, 0);
    check("ret_err", stack_err, 0);

    // Overflow then LIFO drain and underflow
    do_reset();
    run_to('h200);
    for (int i = 0; i < 9; i++) begin
      push = 1'b1; pc_mux = 2'b10;
      step();
      push = 1'b0; pc_mux = 2'b00;
      step();
    end
    check("ovf_depth", stack_depth, 8);
    check("ovf_err", stack_err, 1);
    for (int i = 0; i < 8; i++) begin
      pc_mux = 2'b11;
      step();
      check("lifo_ret", fetch_pc, 'h208 - i);
      pc_mux = 2'b00;
      step();
    end
    pc_mux = 2'b11;
    step();
    pc_mux = 2'b00;
    check("unf_target", fetch_pc, 0);
    check("unf_depth", stack_depth, 0);
    check("unf_err", stack_err, 1);

    // Stall beats redirect, reset beats stall
    do_reset();
    run_to('h030);
    stall = 1'b1; pc_mux = 2'b10;
    repeat (3) step();
    check("stall_fetch_pc", fetch_pc, 'h031);
    check("stall_if_pc", IF_ID_pc, 'h030);
    check("stall_valid", IF_ID_valid, 1);
    check("stall_depth", stack_depth, 0);
    stall = 1'b0;
    step();
    check("unstall_redirect", fetch_pc, 'h050);
    check("unstall_bubble", IF_ID_valid, 0);
    stall = 1'b1; reset = 1'b1;
    step();
    check("rst_stall_fetch_pc", fetch_pc, 0);
    check("rst_stall_if_pc", IF_ID_pc, 0);
    check("rst_stall_instr", IF_ID_instruction, 0);
    check("rst_stall_valid", IF_ID_valid, 0);
    reset = 1'b0; stall = 1'b0; pc_mux = 2'b00;

    // Randomized traffic
    for (int k = 0; k < 4096; k++) mem[k] = INST_W'($urandom);
    repeat (3000) begin
      reset  = ($urandom_range(0, 99) == 0);
      stall  = ($urandom_range(0, 3) == 0);
      pc_mux = 2'($urandom);
      push   = 1'($urandom);
      if (push && pc_mux == 2'b11 && stk.size() == 0) push = 1'b0;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
